mdio_master: RTL and testbench

MDIO_MASTER -- requirements
Module: mdio_master

---
 rtl/mdio_pkg.sv | 21 ++
 rtl/mdio_if.sv | 25 ++
 rtl/mdio_mdc_gen.sv | 41 ++++
 rtl/mdio_master.sv | 198 +++++++++++++++++++
 tb/tb_mdio_master.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 22 MDIO master: FSM state encoding and frame field constants.
package mdio_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PREAMBLE,
        START,
        OPCODE,
        PHY_ADDR,
        REG_ADDR,
        TA,
        DATA,
        DONE
    } mdio_state_e;

    localparam logic [1:0] MDIO_ST       = 2'b01;
    localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
    localparam logic [1:0] MDIO_OP_READ  = 2'b10;
    localparam logic [1:0] MDIO_TA_WRITE = 2'b10;

endpackage

// File: rtl/mdio_if.sv
// Command/response handshake between a requester and the MDIO master.
interface mdio_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_read;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    modport master (
        output cmd_valid, cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

    modport slave (
        input  cmd_valid, cmd_read, cmd_phy_addr, cmd_reg_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error, busy
    );

endinterface

// File: rtl/mdio_mdc_gen.sv
// MDC generator: free-runs only while enabled, low half first, with strobes flagging the
// clk cycle before each MDC edge.
module mdio_mdc_gen #(
    parameter int CLKS_PER_HALF_MDC = 63
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic mdc,
    output logic rise,
    output logic fall,
    output logic sample
);

    localparam logic [7:0] LAST = 8'(CLKS_PER_HALF_MDC - 1);

    logic [7:0] cnt;
    logic       terminal;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            mdc <= 1'b0;
        end else if (cnt == LAST) begin
            cnt <= '0;
            mdc <= ~mdc;
        end else begin
            cnt <= cnt + 8'd1;
        end
    end

    // Input sampling coincides with the bit boundary: last clk of the high phase.
    assign terminal = enable && (cnt == LAST);
    assign rise     = terminal && !mdc;
    assign fall     = terminal && mdc;
    assign sample   = fall;

endmodule

// File: rtl/mdio_master.sv
// Clause 22 MDIO management master: one read or write frame per accepted command.
module mdio_master
    import mdio_pkg::*;
#(
    parameter int CLKS_PER_HALF_MDC = 63,
    parameter int PREAMBLE_BITS     = 32
) (
    input  logic clk,
    input  logic reset_n,
    mdio_if.slave bus,
    input  logic mdio_i,
    output logic mdio_o,
    output logic mdio_t,
    output logic mdc
);

    if (CLKS_PER_HALF_MDC < 4 || CLKS_PER_HALF_MDC > 255) begin : g_bad_half
        $error("mdio_master: CLKS_PER_HALF_MDC out of range 4..255");
    end
    if (PREAMBLE_BITS < 0 || PREAMBLE_BITS > 32) begin : g_bad_pre
        $error("mdio_master: PREAMBLE_BITS out of range 0..32");
    end

    mdio_state_e state;
    logic [4:0]  bit_idx;
    logic [4:0]  idx_dec;
    logic [1:0]  op_q;
    logic [4:0]  phy_q;
    logic [4:0]  reg_q;
    logic [15:0] wdata_q;
    logic [15:0] rd_shift;
    logic        ta_err;
    logic        is_read;
    logic        mdio_s1, mdio_s2;
    logic        gen_en, rise, fall, sample;

    assign idx_dec = bit_idx - 5'd1;
    assign is_read = (op_q == MDIO_OP_READ);
    assign gen_en  = (state != IDLE) && (state != DONE);

    mdio_mdc_gen #(.CLKS_PER_HALF_MDC(CLKS_PER_HALF_MDC)) u_mdc_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .enable  (gen_en),
        .mdc     (mdc),
        .rise    (rise),
        .fall    (fall),
        .sample  (sample)
    );

    always_comb assert (!(rise && fall));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdio_s1 <= 1'b1;
            mdio_s2 <= 1'b1;
        end else begin
            mdio_s1 <= mdio_i;
            mdio_s2 <= mdio_s1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            bit_idx       <= '0;
            op_q          <= '0;
            phy_q         <= '0;
            reg_q         <= '0;
            wdata_q       <= '0;
            rd_shift      <= '0;
            ta_err        <= 1'b0;
            mdio_o        <= 1'b0;
            mdio_t        <= 1'b1;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_error <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (bus.cmd_valid && bus.cmd_ready) begin
                    op_q          <= bus.cmd_read ? MDIO_OP_READ : MDIO_OP_WRITE;
                    phy_q         <= bus.cmd_phy_addr;
                    reg_q         <= bus.cmd_reg_addr;
                    wdata_q       <= bus.cmd_wdata;
                    rd_shift      <= '0;
                    ta_err        <= 1'b0;
                    bus.cmd_ready <= 1'b0;
                    bus.busy      <= 1'b1;
                    mdio_t        <= 1'b0;
                    if (PREAMBLE_BITS > 0) begin
                        state   <= PREAMBLE;
                        bit_idx <= 5'(PREAMBLE_BITS - 1);
                        mdio_o  <= 1'b1;
                    end else begin
                        state   <= START;
                        bit_idx <= 5'd1;
                        mdio_o  <= MDIO_ST[1];
                    end
                end
                PREAMBLE: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= START;
                        bit_idx <= 5'd1;
                        mdio_o  <= MDIO_ST[1];
                    end else begin
                        bit_idx <= idx_dec;
                        mdio_o  <= 1'b1;
                    end
                end
                START: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= OPCODE;
                        bit_idx <= 5'd1;
                        mdio_o  <= op_q[1];
                    end else begin
                        bit_idx <= 5'd0;
                        mdio_o  <= MDIO_ST[0];
                    end
                end
                OPCODE: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= PHY_ADDR;
                        bit_idx <= 5'd4;
                        mdio_o  <= phy_q[4];
                    end else begin
                        bit_idx <= 5'd0;
                        mdio_o  <= op_q[0];
                    end
                end
                PHY_ADDR: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= REG_ADDR;
                        bit_idx <= 5'd4;
                        mdio_o  <= reg_q[4];
                    end else begin
                        bit_idx <= idx_dec;
                        mdio_o  <= phy_q[idx_dec[2:0]];
                    end
                end
                REG_ADDR: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= TA;
                        bit_idx <= 5'd1;
                        // Reads hand the line to the PHY from the first turnaround bit.
                        if (is_read) begin
                            mdio_t <= 1'b1;
                            mdio_o <= 1'b0;
                        end else begin
                            mdio_o <= MDIO_TA_WRITE[1];
                        end
                    end else begin
                        bit_idx <= idx_dec;
                        mdio_o  <= reg_q[idx_dec[2:0]];
                    end
                end
                TA: if (fall) begin
                    if (bit_idx == 5'd0) begin
                        state   <= DATA;
                        bit_idx <= 5'd15;
                        if (is_read && sample) ta_err <= mdio_s2;
                        if (!is_read) mdio_o <= wdata_q[15];
                    end else begin
                        bit_idx <= 5'd0;
                        if (!is_read) mdio_o <= MDIO_TA_WRITE[0];
                    end
                end
                DATA: if (fall) begin
                    if (is_read && sample) rd_shift <= {rd_shift[14:0], mdio_s2};
                    if (bit_idx == 5'd0) begin
                        state  <= DONE;
                        mdio_t <= 1'b1;
                        mdio_o <= 1'b0;
                    end else begin
                        bit_idx <= idx_dec;
                        if (!is_read) mdio_o <= wdata_q[idx_dec[3:0]];
                    end
                end
                DONE: begin
                    // Two cycles: response pulse, then back to IDLE with cmd_ready.
                    if (!bus.rsp_valid) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= is_read ? rd_shift : '0;
                        bus.rsp_error <= is_read && ta_err;
                    end else begin
                        state         <= IDLE;
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// Directed bench for mdio_master: bit-accurate frame capture, PHY read model, latency and reset checks.
module tb_mdio_master;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    mdio_if bus ();
    mdio_if bus0 ();

    logic phy_mdio = 1'b1;
    logic mdio_o, mdio_t, mdc;
    logic mdio_i0 = 1'b1;
    logic mdio_o0, mdio_t0, mdc0;

    mdio_master #(.CLKS_PER_HALF_MDC(4), .PREAMBLE_BITS(32)) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .mdio_i(phy_mdio), .mdio_o(mdio_o), .mdio_t(mdio_t), .mdc(mdc)
    );

    mdio_master #(.CLKS_PER_HALF_MDC(63), .PREAMBLE_BITS(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0),
        .mdio_i(mdio_i0), .mdio_o(mdio_o0), .mdio_t(mdio_t0), .mdc(mdc0)
    );

    int n_checks = 0;
    int n_fail = 0;

    // Command for the next frame and the one queued behind it in the hold test
    logic        c_read, nxt_read;
    logic [4:0]  c_phy, c_reg, nxt_phy, nxt_reg;
    logic [15:0] c_wdata, nxt_wdata;

    // Frame capture results (bit k of the frame lands in position 63-k)
    logic [63:0] fr_bits, fr_tbits;
    int          fr_lat, fr_pulses, fr_mdc_bad, fr_stable_bad;
    logic [15:0] fr_rdata;
    logic        fr_err, fr_mdc_end, fr_t_end, fr_ready_at, fr_ready_after, fr_busy0;

    function automatic logic phy_bit(input int k, input bit present, input bit ta1, input logic [15:0] pdata);
        if (!present) return 1'b1;
        if (k < 47) return 1'b1;
        if (k == 47) return ta1;
        return pdata[63 - k];
    endfunction

    task automatic run_frame(input bit issue, input bit hold, input bit present, input bit ta1, input logic [15:0] pdata);
        int  c;
        bit  done;
        logic prev_o, prev_t;
        fr_bits = '0; fr_tbits = '0; fr_lat = -1; fr_pulses = 0;
        fr_mdc_bad = 0; fr_stable_bad = 0; fr_rdata = 'x; fr_err = 'x;
        fr_mdc_end = 'x; fr_t_end = 'x; fr_ready_at = 'x; fr_ready_after = 'x;
        if (issue) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_read = c_read; bus.cmd_phy_addr = c_phy;
            bus.cmd_reg_addr = c_reg; bus.cmd_wdata = c_wdata;
        end
        @(posedge clk); #1;
        fr_busy0 = bus.busy;
        if (!hold) bus.cmd_valid = 1'b0;
        c = 0; done = 0;
        prev_o = mdio_o; prev_t = mdio_t;
        while (!done) begin
            if (c < 512) begin
                if (mdc !== ((c % 8) >= 4)) fr_mdc_bad++;
                if ((c % 8) != 0 && (mdio_o !== prev_o || mdio_t !== prev_t)) fr_stable_bad++;
                if ((c % 8) == 2) begin
                    fr_bits[63 - c / 8] = mdio_o;
                    fr_tbits[63 - c / 8] = mdio_t;
                end
                if ((c % 8) == 1) phy_mdio = phy_bit(c / 8, present, ta1, pdata);
            end
            prev_o = mdio_o; prev_t = mdio_t;
            if (bus.rsp_valid === 1'b1) begin
                fr_pulses++;
                if (fr_lat < 0) begin
                    fr_lat = c; fr_rdata = bus.rsp_rdata; fr_err = bus.rsp_error;
                    fr_mdc_end = mdc; fr_t_end = mdio_t; fr_ready_at = bus.cmd_ready;
                end
            end
            if (hold) begin
                if (fr_lat >= 0) begin
                    bus.cmd_read = nxt_read; bus.cmd_phy_addr = nxt_phy;
                    bus.cmd_reg_addr = nxt_reg; bus.cmd_wdata = nxt_wdata;
                end else begin
                    bus.cmd_read = c[1]; bus.cmd_phy_addr = 5'(c * 7);
                    bus.cmd_reg_addr = 5'(c * 3); bus.cmd_wdata = 16'(c * 911);
                end
            end
            if (fr_lat >= 0 && c == fr_lat + 1) begin
                fr_ready_after = bus.cmd_ready;
                done = 1;
            end else if (c >= 700) begin
                done = 1;
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        phy_mdio = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (mdc !== 1'b0) begin n_fail++; $display("FAIL reset_mdc got=%b exp=0", mdc); end
        n_checks++; if (mdio_t !== 1'b1) begin n_fail++; $display("FAIL reset_mdio_t got=%b exp=1", mdio_t); end
        n_checks++; if (mdio_o !== 1'b0) begin n_fail++; $display("FAIL reset_mdio_o got=%b exp=0", mdio_o); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0000", bus.rsp_rdata); end
        n_checks++; if (bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_error got=%b exp=0", bus.rsp_error); end
        n_checks++; if (mdc0 !== 1'b0 || mdio_t0 !== 1'b1) begin n_fail++; $display("FAIL reset_dut0_pads got=%b%b exp=01", mdc0, mdio_t0); end
    endtask

    task automatic test_write();
        c_read = 1'b0; c_phy = 5'h0C; c_reg = 5'h18; c_wdata = 16'h0030;
        run_frame(1, 0, 0, 0, 16'h0000);
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_5662_0030) begin n_fail++; $display("FAIL wr_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_5662_0030); end
        n_checks++; if (fr_tbits !== 64'h0) begin n_fail++; $display("FAIL wr_mdio_t got=%h exp=0", fr_tbits); end
        n_checks++; if (fr_lat !== 513) begin n_fail++; $display("FAIL wr_latency got=%0d exp=513", fr_lat); end
        n_checks++; if (fr_rdata !== 16'h0000 || fr_err !== 1'b0) begin n_fail++; $display("FAIL wr_rsp got=%h/%b exp=0000/0", fr_rdata, fr_err); end
        n_checks++; if (fr_pulses !== 1) begin n_fail++; $display("FAIL wr_pulses got=%0d exp=1", fr_pulses); end
        n_checks++; if (fr_mdc_bad !== 0) begin n_fail++; $display("FAIL wr_mdc_shape got=%0d exp=0", fr_mdc_bad); end
        n_checks++; if (fr_stable_bad !== 0) begin n_fail++; $display("FAIL wr_mdio_stable got=%0d exp=0", fr_stable_bad); end
        n_checks++; if (fr_mdc_end !== 1'b0 || fr_t_end !== 1'b1) begin n_fail++; $display("FAIL wr_done_pads got=%b%b exp=01", fr_mdc_end, fr_t_end); end
        n_checks++; if (fr_ready_at !== 1'b0 || fr_ready_after !== 1'b1) begin n_fail++; $display("FAIL wr_ready_return got=%b%b exp=01", fr_ready_at, fr_ready_after); end
    endtask

    task automatic test_read();
        c_read = 1'b1; c_phy = 5'h01; c_reg = 5'h02; c_wdata = 16'hDEAD;
        run_frame(1, 0, 1, 0, 16'h0141);
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_6088_0000) begin n_fail++; $display("FAIL rd_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_6088_0000); end
        n_checks++; if (fr_tbits !== 64'h0000_0000_0003_FFFF) begin n_fail++; $display("FAIL rd_mdio_t got=%h exp=%h", fr_tbits, 64'h3FFFF); end
        n_checks++; if (fr_rdata !== 16'h0141) begin n_fail++; $display("FAIL rd_rdata got=%h exp=0141", fr_rdata); end
        n_checks++; if (fr_err !== 1'b0) begin n_fail++; $display("FAIL rd_error got=%b exp=0", fr_err); end
        n_checks++; if (fr_lat !== 513) begin n_fail++; $display("FAIL rd_latency got=%0d exp=513", fr_lat); end
        n_checks++; if (fr_stable_bad !== 0) begin n_fail++; $display("FAIL rd_mdio_stable got=%0d exp=0", fr_stable_bad); end
        repeat (5) @(negedge clk);
        n_checks++; if (bus.rsp_rdata !== 16'h0141 || bus.rsp_error !== 1'b0) begin n_fail++; $display("FAIL rd_hold got=%h/%b exp=0141/0", bus.rsp_rdata, bus.rsp_error); end
    endtask

    task automatic test_read_absent();
        c_read = 1'b1; c_phy = 5'h05; c_reg = 5'h01; c_wdata = 16'h0000;
        run_frame(1, 0, 0, 0, 16'h0000);
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_6284_0000) begin n_fail++; $display("FAIL absent_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_6284_0000); end
        n_checks++; if (fr_rdata !== 16'hFFFF) begin n_fail++; $display("FAIL absent_rdata got=%h exp=FFFF", fr_rdata); end
        n_checks++; if (fr_err !== 1'b1) begin n_fail++; $display("FAIL absent_error got=%b exp=1", fr_err); end
    endtask

    task automatic test_back_to_back();
        c_read = 1'b0; c_phy = 5'h1F; c_reg = 5'h00; c_wdata = 16'hA5C3;
        nxt_read = 1'b0; nxt_phy = 5'h12; nxt_reg = 5'h0F; nxt_wdata = 16'h1234;
        run_frame(1, 1, 0, 0, 16'h0000);
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_5F82_A5C3) begin n_fail++; $display("FAIL b2b_first_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_5F82_A5C3); end
        n_checks++; if (fr_pulses !== 1) begin n_fail++; $display("FAIL b2b_first_pulses got=%0d exp=1", fr_pulses); end
        n_checks++; if (fr_lat !== 513) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=513", fr_lat); end
        n_checks++; if (fr_ready_after !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_return got=%b exp=1", fr_ready_after); end
        run_frame(0, 0, 0, 0, 16'h0000);
        n_checks++; if (fr_busy0 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_accept got=%b exp=1", fr_busy0); end
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_593E_1234) begin n_fail++; $display("FAIL b2b_second_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_593E_1234); end
        n_checks++; if (fr_lat !== 513) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=513", fr_lat); end
    endtask

    task automatic test_reset_mid_frame();
        int seen;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_read = 1'b0; bus.cmd_phy_addr = 5'h0C;
        bus.cmd_reg_addr = 5'h18; bus.cmd_wdata = 16'h0030;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        repeat (40 * 8 + 3) @(posedge clk);
        #2;
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got=%b exp=1", bus.busy); end
        reset_n = 1'b0; #1;
        n_checks++; if (mdc !== 1'b0 || mdio_t !== 1'b1 || mdio_o !== 1'b0) begin n_fail++; $display("FAIL midrst_pads got=%b%b%b exp=010", mdc, mdio_t, mdio_o); end
        n_checks++; if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_status got=%b%b exp=00", bus.busy, bus.rsp_valid); end
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        seen = 0;
        repeat (600) begin @(posedge clk); #1; if (bus.rsp_valid === 1'b1) seen++; end
        n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got=%0d exp=0", seen); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got=%b exp=1", bus.cmd_ready); end
        c_read = 1'b0; c_phy = 5'h0C; c_reg = 5'h18; c_wdata = 16'h0030;
        run_frame(1, 0, 0, 0, 16'h0000);
        n_checks++; if (fr_bits !== 64'hFFFF_FFFF_5662_0030) begin n_fail++; $display("FAIL midrst_next_bits got=%h exp=%h", fr_bits, 64'hFFFF_FFFF_5662_0030); end
        n_checks++; if (fr_lat !== 513) begin n_fail++; $display("FAIL midrst_next_latency got=%0d exp=513", fr_lat); end
    endtask

    task automatic test_no_preamble();
        int c, lat, tbad;
        logic [31:0] bits;
        @(negedge clk);
        bus0.cmd_valid = 1'b1; bus0.cmd_read = 1'b0; bus0.cmd_phy_addr = 5'h0C;
        bus0.cmd_reg_addr = 5'h18; bus0.cmd_wdata = 16'h0030;
        @(posedge clk); #1;
        bus0.cmd_valid = 1'b0;
        c = 0; lat = -1; tbad = 0; bits = '0;
        while (lat < 0 && c < 5000) begin
            if (c < 4032 && (c % 126) == 2) begin
                bits[31 - c / 126] = mdio_o0;
                if (mdio_t0 !== 1'b0) tbad++;
            end
            if (bus0.rsp_valid === 1'b1) lat = c;
            else begin @(posedge clk); #1; c++; end
        end
        n_checks++; if (bits[31] !== 1'b0) begin n_fail++; $display("FAIL nopre_first_bit got=%b exp=0", bits[31]); end
        n_checks++; if (bits !== 32'h5662_0030) begin n_fail++; $display("FAIL nopre_bits got=%h exp=56620030", bits); end
        n_checks++; if (tbad !== 0) begin n_fail++; $display("FAIL nopre_mdio_t got=%0d exp=0", tbad); end
        n_checks++; if (lat !== 4033) begin n_fail++; $display("FAIL nopre_latency got=%0d exp=4033", lat); end
        n_checks++; if (mdc0 !== 1'b0 || mdio_t0 !== 1'b1) begin n_fail++; $display("FAIL nopre_done_pads got=%b%b exp=01", mdc0, mdio_t0); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_read = 1'b0; bus.cmd_phy_addr = '0;
        bus.cmd_reg_addr = '0; bus.cmd_wdata = '0;
        bus0.cmd_valid = 1'b0; bus0.cmd_read = 1'b0; bus0.cmd_phy_addr = '0;
        bus0.cmd_reg_addr = '0; bus0.cmd_wdata = '0;
        repeat (5) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_write();
        test_read();
        test_read_absent();
        test_back_to_back();
        test_reset_mid_frame();
        test_no_preamble();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
